// File: rtl/division_arbiter.sv
// Round-robin front end that shares one sequential 32-bit Division core among N_REQ requesters.
// Latency: accept->div_start 1 cycle, accept->response L+2 cycles (L = core latency), divide-by-zero answered in 1 cycle.
// Backpressure: one request in flight; new requests only accepted in IDLE, response held until rsp_ready.
module division_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_dividend,
    input  logic [32*N_REQ-1:0]   req_divider,
    input  logic [N_REQ-1:0]      req_sign,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_quotient,
    output logic [31:0]           rsp_remainder,
    output logic [1:0]            rsp_err,
    output logic [31:0]           div_dividend,
    output logic [31:0]           div_divider,
    output logic                  div_sign,
    output logic                  div_start,
    input  logic                  div_ready,
    input  logic [31:0]           div_quotient,
    input  logic [31:0]           div_remainder
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       quo_q, quo_d;
    logic [31:0]       rem_q, rem_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       dvd_q, dvd_d;
    logic [31:0]       dvr_q, dvr_d;
    logic              sgn_q, sgn_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W:0]     cand;
    logic [31:0]       sel_dividend;
    logic [31:0]       sel_divider;

    // Cyclic search for the first asserted request at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    assign sel_dividend = req_dividend[{gnt_id, 5'b00000} +: 32];
    assign sel_divider  = req_divider[{gnt_id, 5'b00000} +: 32];

    // Next-state and strobe outputs; strobes forced low while reset is asserted.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        err_d     = err_q;
        dvd_d     = dvd_q;
        dvr_d     = dvr_q;
        sgn_d     = sgn_q;
        wd_d      = wd_q;
        req_ready = '0;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_id] = 1'b1;
                    id_d              = gnt_id;
                    if (sel_divider == 32'd0) begin
                        // Answered locally; the core never sees this request.
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = sel_dividend;
                        err_d   = ERR_DIV0;
                        state_d = RESP;
                    end else begin
                        dvd_d   = sel_dividend;
                        dvr_d   = sel_divider;
                        sgn_d   = req_sign[gnt_id];
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                wd_d      = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                // wd_q == 0 marks the first WAIT cycle, where div_ready may still be stale.
                if ((wd_q != '0) && div_ready) begin
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            req_ready = '0;
            div_start = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            err_q    <= ERR_OK;
            dvd_q    <= '0;
            dvr_q    <= '0;
            sgn_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            dvd_q    <= dvd_d;
            dvr_q    <= dvr_d;
            sgn_q    <= sgn_d;
            wd_q     <= wd_d;
        end
    end

    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = id_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_err       = err_q;
    assign div_dividend  = dvd_q;
    assign div_divider   = dvr_q;
    assign div_sign      = sgn_q;

endmodule

// File: tb/tb_division_arbiter.sv
// Directed bench for division_arbiter with a 33-cycle behavioural Division core.
module tb_division_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 33;

    logic                clk = 1'b0;
    logic                reset;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_dividend;
    logic [32*N_REQ-1:0] req_divider;
    logic [N_REQ-1:0]    req_sign;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_quotient;
    logic [31:0]         rsp_remainder;
    logic [1:0]          rsp_err;
    logic [31:0]         div_dividend;
    logic [31:0]         div_divider;
    logic                div_sign;
    logic                div_start;
    logic                div_ready;
    logic [31:0]         div_quotient;
    logic [31:0]         div_remainder;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int starts   = 0;

    division_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divider   (req_divider),
        .req_sign      (req_sign),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .div_dividend  (div_dividend),
        .div_divider   (div_divider),
        .div_sign      (div_sign),
        .div_start     (div_start),
        .div_ready     (div_ready),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) starts <= starts + 1;
    end

    // Behavioural core: result ready LAT cycles after the start pulse; core_dead suppresses it.
    logic        core_dead = 1'b0;
    int          core_cnt  = 0;
    logic [31:0] core_q, core_r;
    always @(posedge clk) begin
        if (div_start) begin
            core_cnt <= LAT;
            if (div_divider == 32'd0) begin
                core_q <= '0;
                core_r <= '0;
            end else if (div_sign) begin
                core_q <= $signed(div_dividend) / $signed(div_divider);
                core_r <= $signed(div_dividend) % $signed(div_divider);
            end else begin
                core_q <= div_dividend / div_divider;
                core_r <= div_dividend % div_divider;
            end
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
        end
    end
    assign div_ready     = (core_cnt == 1) && !core_dead;
    assign div_quotient  = core_q;
    assign div_remainder = core_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request and wait for its accept pulse; returns the accept cycle and leaves valid low.
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic s, output int acc);
        acc = -1;
        req_dividend[id*32 +: 32] = a;
        req_divider[id*32 +: 32]  = b;
        req_sign[id]              = s;
        req_valid[id]             = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (req_ready[id]) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    // Wait for any accept pulse among already-asserted requests; clears the granted valid bit.
    task automatic wait_grant(output logic [N_REQ-1:0] g, output int gc);
        g  = '0;
        gc = -1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (req_ready != '0) begin
                g  = req_ready;
                gc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (gc < 0) chk("grant_timeout", 64'd0, 64'd1);
        @(negedge clk);
        req_valid = req_valid & ~g;
    endtask

    task automatic wait_rsp(output int vc);
        vc = -1;
        for (int n = 0; n < 200; n++) begin
            if (rsp_valid) begin
                vc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (vc < 0) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    // Wait for a response, sample it, and complete the handshake; hs is the handshake cycle.
    task automatic get_rsp(output logic [ID_W-1:0] id, output logic [31:0] q, output logic [31:0] r,
                           output logic [1:0] e, output int vc, output int hs);
        wait_rsp(vc);
        id = rsp_id;
        q  = rsp_quotient;
        r  = rsp_remainder;
        e  = rsp_err;
        hs = cyc;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_div_start"}, 64'(div_start), 64'd0);
        chk({tag, "_rsp_fields"}, {rsp_quotient, rsp_remainder}, 64'd0);
        chk({tag, "_rsp_id_err"}, 64'({rsp_id, rsp_err}), 64'd0);
        chk({tag, "_div_ops"}, {div_dividend, div_divider}, 64'd0);
        chk({tag, "_div_sign"}, 64'(div_sign), 64'd0);
    endtask

    logic [ID_W-1:0]  r_id;
    logic [31:0]      r_q, r_r;
    logic [1:0]       r_e;
    logic [N_REQ-1:0] g;
    int acc, vc, hs, gc, s0;

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divider  = '0;
        req_sign     = '0;
        rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Requester 0: 4/2 unsigned.
        s0 = starts;
        send(0, 32'd4, 32'd2, 1'b0, acc);
        chk("t1_start_at_T1", 64'(div_start), 64'd1);
        chk("t1_div_ops", {div_dividend, div_divider}, {32'd4, 32'd2});
        @(negedge clk);
        chk("t1_start_one_cycle", 64'(div_start), 64'd0);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t1_latency", 64'(vc - acc), 64'(LAT + 2));
        chk("t1_rsp", {30'd0, r_id, r_e, r_q}, {30'd0, 2'd0, 2'b00, 32'd2});
        chk("t1_rem", 64'(r_r), 64'd0);
        chk("t1_start_count", 64'(starts - s0), 64'd1);

        // Requester 1: 16/5 unsigned then 8/2 signed.
        send(1, 32'd16, 32'd5, 1'b0, acc);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t2a_rsp", {r_q, r_r}, {32'd3, 32'd1});
        chk("t2a_id_err", 64'({r_id, r_e}), 64'({2'd1, 2'b00}));
        send(1, 32'd8, 32'd2, 1'b1, acc);
        chk("t2b_div_sign", 64'(div_sign), 64'd1);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t2b_rsp", {r_q, r_r}, {32'd4, 32'd0});
        chk("t2b_id_err", 64'({r_id, r_e}), 64'({2'd1, 2'b00}));

        // Requester 3: 7/0 answered locally, core untouched; rr_ptr wraps 3 -> 0.
        s0 = starts;
        send(3, 32'd7, 32'd0, 1'b0, acc);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t4_latency", 64'(vc - acc), 64'd1);
        chk("t4_rsp", {r_q, r_r}, {32'hFFFF_FFFF, 32'd7});
        chk("t4_id_err", 64'({r_id, r_e}), 64'({2'd3, 2'b01}));
        chk("t4_no_start", 64'(starts - s0), 64'd0);

        // Requesters 0 and 2 together with rr_ptr 0; 0 re-requests right away.
        req_dividend[0*32 +: 32] = 32'd9;
        req_divider[0*32 +: 32]  = 32'd3;
        req_dividend[2*32 +: 32] = 32'd20;
        req_divider[2*32 +: 32]  = 32'd6;
        req_sign  = '0;
        req_valid = 4'b0101;
        wait_grant(g, gc);
        chk("t3_first_grant", 64'(g), 64'b0001);
        req_dividend[0*32 +: 32] = 32'd10;
        req_divider[0*32 +: 32]  = 32'd4;
        req_valid[0] = 1'b1;
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t3_rsp0", {30'd0, r_id, r_q}, {30'd0, 2'd0, 32'd3});
        wait_grant(g, gc);
        chk("t3_second_grant", 64'(g), 64'b0100);
        chk("t3_idle_gap", 64'(gc - hs), 64'd1);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t3_rsp2", {30'd0, r_id, r_q}, {30'd0, 2'd2, 32'd3});
        chk("t3_rsp2_rem", 64'(r_r), 64'd2);
        wait_grant(g, gc);
        chk("t3_third_grant", 64'(g), 64'b0001);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t3_rsp0b", {r_q, r_r}, {32'd2, 32'd2});
        chk("t3_rsp0b_id", 64'(r_id), 64'd0);

        // Core never answers: watchdog response, held stable under backpressure.
        core_dead = 1'b1;
        s0 = starts;
        send(1, 32'd100, 32'd7, 1'b0, acc);
        wait_rsp(vc);
        chk("t5_latency", 64'(vc - acc), 64'(64 + 2));
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t5_hold_fields", {rsp_quotient, rsp_remainder}, 64'd0);
            chk("t5_hold_id_err", 64'({rsp_id, rsp_err}), 64'({2'd1, 2'b10}));
            @(negedge clk);
        end
        chk("t5_start_count", 64'(starts - s0), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t5_released", 64'(rsp_valid), 64'd0);
        core_dead = 1'b0;

        // Reset during WAIT, then rr_ptr back at 0: requesters 1 and 3 -> 1 wins.
        send(2, 32'd50, 32'd5, 1'b0, acc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_reset");
        reset = 1'b0;
        req_dividend[1*32 +: 32] = 32'd16;
        req_divider[1*32 +: 32]  = 32'd5;
        req_dividend[3*32 +: 32] = 32'd21;
        req_divider[3*32 +: 32]  = 32'd4;
        req_valid = 4'b1010;
        wait_grant(g, gc);
        chk("t6_grant_after_reset", 64'(g), 64'b0010);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t6_rsp1", {r_q, r_r}, {32'd3, 32'd1});
        chk("t6_rsp1_id_err", 64'({r_id, r_e}), 64'({2'd1, 2'b00}));
        wait_grant(g, gc);
        chk("t6_grant3", 64'(g), 64'b1000);
        get_rsp(r_id, r_q, r_r, r_e, vc, hs);
        chk("t6_rsp3", {r_q, r_r}, {32'd5, 32'd1});
        chk("t6_rsp3_id", 64'(r_id), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/division_arbiter.md
# division_arbiter

Shares one 32-bit sequential `Division` core among N_REQ requesters with round-robin arbitration. Per request: captures operands, issues them to the core, waits for `ready`, returns quotient/remainder tagged with the requester id. Divide-by-zero requests are answered locally without occupying the core, and a watchdog bounds every core operation. Sits between the datapath's requesters and the single `Division` instance.

## Interface

- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester id; must equal ceil(log2(N_REQ))
- TIMEOUT, 64, max cycles in WAIT before forcing an error response (must exceed core latency of 33)
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester request
- req_ready  output  N_REQ  one-hot one-cycle accept pulse
- req_dividend  input  32*N_REQ  packed dividends; requester k at [32k+31:32k]
- req_divider  input  32*N_REQ  packed divisors
- req_sign  input  N_REQ  1 = signed division
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  ID_W  requester that owns the response
- rsp_quotient  output  32  quotient
- rsp_remainder  output  32  remainder
- rsp_err  output  2  00 ok, 01 divide-by-zero, 10 timeout
- div_dividend, div_divider  output  32 each  operands to core; held stable from ISSUE through WAIT
- div_sign  output  1  sign mode to core
- div_start  output  1  one-cycle start pulse to core
- div_ready  input  1  core done
- div_quotient, div_remainder  input  32 each  core results

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first asserted index at or after rr_ptr (cyclic). Assert req_ready[g] that cycle; register operands, sign, id. If captured divider == 0: next RESP with quotient = 32'hFFFF_FFFF, remainder = dividend, err = 01. Else next ISSUE.
- ISSUE: div_start = 1 for exactly one cycle; clear watchdog counter; next WAIT.
- WAIT: div_ready ignored in the first WAIT cycle (stale ready from previous op). From the second cycle, div_ready = 1 -> capture div_quotient/div_remainder, err = 00, next RESP. Counter reaching TIMEOUT -> quotient = remainder = 0, err = 10, next RESP.
- RESP: rsp_valid = 1; rsp_* stable until rsp_valid && rsp_ready. On handshake: rr_ptr = (g+1) mod N_REQ, next IDLE.
- Requests are not accepted outside IDLE; requesters hold req_valid and operands until their req_ready pulse.
- Sign interpretation is delegated to the core; operands are passed unmodified.
- Only granted requests advance rr_ptr; a requester cannot win twice while another is waiting.

## Timing

- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_quotient 0, rsp_remainder 0, rsp_err 00, div_start 0, div_dividend 0, div_divider 0, div_sign 0.
- Accept-to-start: req_ready in cycle T, div_start in T+1.
- Accept-to-response (core latency L cycles after start): rsp_valid first high at T+L+2 at the earliest.
- Divide-by-zero: rsp_valid at T+1; core untouched (div_start stays 0).
- Minimum IDLE gap: one cycle after RESP handshake before next req_ready.
- Reset mid-operation: returns to IDLE next cycle; in-flight core result discarded; any pending response lost; div_start low.
- req_valid and rsp_ready simultaneous in RESP: response completes; new request granted in the following IDLE cycle.
- rr_ptr wraps N_REQ-1 -> 0.

## Test plan

- Single requester 0, 4/2 unsigned -> rsp_id 0, quotient 2, remainder 0, err 00; div_start exactly one pulse.
- Requester 1, 16/5 unsigned then 8/2 signed -> (3, 1) then (4, 0), both err 00, responses in order.
- Requesters 0 and 2 assert together with rr_ptr 0 -> grant 0 first, then 2; repeat with 0 re-requesting -> 2 served before 0's second request.
- Requester 3, 7/0 -> rsp at accept+1, quotient FFFF_FFFF, remainder 7, err 01, no div_start.
- Core model never asserts div_ready -> response after TIMEOUT WAIT cycles with err 10; rsp_ready held low 5 cycles -> rsp_* stable throughout.
- Reset asserted in WAIT -> next cycle all outputs at reset values; a later 16/5 request completes correctly.
